mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 256, number of 16-bit words stored (power of two, 2..65536).
REQ-002 Parameter: LATENCY, default 2, cycles from request acceptance to mem_resp (1..15).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_read  input  1  read request, held by the initiator until mem_resp.
REQ-006 mem_write  input  1  write request, held by the initiator until mem_resp.
REQ-007 mem_byte_enable  input  2 (lc3b_mem_wmask)  write byte mask; bit0 = low byte, bit1 = high byte.
REQ-008 mem_address  input  16 (lc3b_word)  byte address; bit0 ignored.
REQ-009 mem_wdata  input  16 (lc3b_word)  write data.
REQ-010 mem_resp  output  1  one-cycle completion pulse.
REQ-011 mem_rdata  output  16 (lc3b_word)  read data, valid only while mem_resp=1.
REQ-012 prot_err  output  1  sticky protocol-error flag.

Function
REQ-013 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-014 IDLE: (mem_read|mem_write)=1 at an edge -> capture address, wdata, mask and op; go to BUSY with counter=LATENCY-1; LATENCY=1 goes directly to RESP.
REQ-015 BUSY: decrement counter each edge; at 0 go to RESP; mem_resp asserts exactly LATENCY cycles after the accepting edge.
REQ-016 RESP: mem_resp=1 for exactly one cycle, then IDLE unconditionally; a request present in the RESP cycle is not accepted until the following IDLE cycle.
REQ-017 Back-to-back: a request asserted in the cycle after RESP is accepted; sustained throughput is one transfer per LATENCY+1 cycles.
REQ-018 Word index = captured mem_address[log2(DEPTH_WORDS):1]; higher address bits are ignored (aliasing wrap-around).
REQ-019 Read: mem_rdata = array[index] registered on entry to RESP; mem_rdata = 16'h0000 when mem_resp=0.
REQ-020 Write: array bytes selected by the captured mask are updated at the edge entering RESP; mask 2'b00 writes nothing but still responds.
REQ-021 A read accepted after a write's RESP cycle returns the written data.
REQ-022 Request deasserted while in BUSY: abort, return to IDLE, no mem_resp, no array update.
REQ-023 Address/data changes during BUSY are ignored; the captured values are used.
REQ-024 mem_read and mem_write both 1 at acceptance: treated as a write; prot_err set (when enabled).

Reset
REQ-025 rst_n=0 at any time forces IDLE, mem_resp=0, mem_rdata=0, counter=0, prot_err=0 immediately.
REQ-026 Array contents are not reset; an in-flight write aborted by reset is not committed.

Configuration
REQ-027 Macro MEM_RESPONDER_PROTCHK_EN defined: prot_err sets on REQ-024, on REQ-022 abort, or on op change during BUSY; it is cleared only by reset.
REQ-028 MEM_RESPONDER_PROTCHK_EN undefined: prot_err tied to 0 and no check logic is synthesised; all other behaviour is identical.

Structure
REQ-029 lc3b_types holds lc3b_word, lc3b_mem_wmask and a new enum lc3b_memresp_state {IDLE, BUSY, RESP}.
REQ-030 The storage is a sub-module mem_responder_array: synchronous byte-masked write, registered read, no reset.

Verification
REQ-031 LATENCY=2: write 16'hBEEF to 16'h0010 with mask 2'b11, then read 16'h0010 -> each mem_resp 2 cycles after acceptance; rdata=16'hBEEF.
REQ-032 Mask 2'b01 writes 16'h1234 over 16'hBEEF at 16'h0010 -> subsequent read returns 16'hBE34.
REQ-033 DEPTH_WORDS=256: write 16'hA5A5 to 16'h0002, read 16'h0202 -> returns 16'hA5A5 (alias).
REQ-034 Read asserted then dropped after 1 cycle (LATENCY=3) -> no mem_resp; prot_err=1 with macro, 0 without.
REQ-035 rst_n pulled low in BUSY during a write of 16'hFFFF to 16'h0020 -> outputs 0 immediately; later read of 16'h0020 returns the prior value.
REQ-036 mem_read=mem_write=1 with wdata 16'h0F0F -> one mem_resp; array updated; prot_err=1 (macro defined).

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types.
//   lc3b_word          : 16-bit data / byte address
//   lc3b_mem_wmask     : byte write mask, bit0 = low byte, bit1 = high byte
//   lc3b_memresp_state : responder FSM states
//   lc3b_memreq_t      : one captured request (address, data, mask, op)
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lc3b_memresp_state;

  typedef struct packed {
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_mem_wmask mask;
    logic          wr;     // 1 = write (also used when read and write are both raised)
  } lc3b_memreq_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder.
// Synchronous byte-masked write, registered read, contents never reset.
// Ports:
//   clk    : clock
//   we     : write strobe, bytes selected by wmask are written at the edge
//   re     : read strobe, rdata loads storage[idx] at the edge
//   idx    : word index
//   wmask  : byte write mask
//   wdata  : write data
//   rdata  : registered read data
module mem_responder_array
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  lc3b_mem_wmask wmask,
  input  lc3b_word      wdata,
  output lc3b_word      rdata
);

  logic [1:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 2; b++) begin
        if (wmask[b]) mem[idx][b] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for an LC-3b style hold-until-resp bus.
// A request is captured in IDLE, waits LATENCY-1 cycles in BUSY and completes
// with a one-cycle mem_resp pulse (RESP), after which the FSM returns to IDLE.
// Dropping the request while BUSY aborts it without touching storage.
// Optional feature: define MEM_RESPONDER_PROTCHK_EN to build the sticky
// protocol checker behind prot_err; otherwise prot_err is constant 0.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   mem_read/write   : request strobes, held until mem_resp
//   mem_byte_enable  : write byte mask
//   mem_address      : byte address (bit0 ignored, high bits alias)
//   mem_wdata        : write data
//   mem_resp         : one-cycle completion pulse
//   mem_rdata        : read data, zero whenever mem_resp is low
//   prot_err         : sticky protocol-error flag
module mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          prot_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  lc3b_memresp_state state;
  logic [3:0]        cnt;
  lc3b_memreq_t      cap;
  lc3b_memreq_t      live;
  lc3b_memreq_t      cur;
  logic              req;
  logic              accept;
  logic              finish;
  logic [AW-1:0]     idx;
  lc3b_word          arr_rdata;

  assign req    = mem_read | mem_write;
  assign live   = {mem_address, mem_wdata, mem_byte_enable, mem_write};
  assign accept = (state == IDLE) && req;

  // The edge that enters RESP commits the access. With LATENCY=1 that is the
  // accepting edge itself, so the live bus is used instead of the capture.
  assign finish = ((state == BUSY) && req && (cnt == 4'd1)) ||
                  (accept && (LATENCY == 1));
  assign cur    = (state == IDLE) ? live : cap;

  // Zero-extend before dropping the byte bit so DEPTH_WORDS=65536 still works.
  assign idx = AW'({1'b0, cur.addr} >> 1);

  mem_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (finish && cur.wr),
    .re   (finish && !cur.wr),
    .idx  (idx),
    .wmask(cur.mask),
    .wdata(cur.wdata),
    .rdata(arr_rdata)
  );

  // Storage output register is not reset; gating keeps rdata clean outside RESP.
  assign mem_rdata = mem_resp ? arr_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cap      <= '0;
      mem_resp <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap <= live;
            if (LATENCY == 1) begin
              state    <= RESP;
              mem_resp <= 1'b1;
              cnt      <= '0;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state    <= RESP;
            mem_resp <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_PROTCHK_EN
  // Flags: both strobes at acceptance, abort in BUSY, or op flip in BUSY.
  logic prot_hit;
  assign prot_hit = (accept && mem_read && mem_write) ||
                    ((state == BUSY) && (!req || (mem_write != cap.wr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        prot_err <= 1'b0;
    else if (prot_hit) prot_err <= 1'b1;
  end
`else
  assign prot_err = 1'b0;
`endif

endmodule
